// File: rtl/pattern_receiver.sv
// Serial MSB-first receiver/checker for the shift-register pattern link.
// Deserializes a 16-bit dynamic or 88-bit static frame and counts mismatching bits.
module pattern_receiver #(
  parameter int unsigned                    SIZESRSTAT = 88,
  parameter int unsigned                    SIZESRDYN  = 16,
  parameter int unsigned                    SIZECNT    = 7,
  parameter int unsigned                    LATENCY    = 1,
  parameter logic [SIZESRDYN-1:0]           EXP_DYN    = 16'hABCD,
  parameter logic [SIZESRSTAT-1:0]          EXP_STAT   = 88'h123456789ABCDEF1234567
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  MODE,
  input  logic                  signal_in,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  MATCH,
  output logic [SIZECNT-1:0]    ERR_CNT,
  output logic [SIZESRDYN-1:0]  RX_DYN,
  output logic [SIZESRSTAT-1:0] RX_STAT
);

  localparam int unsigned LATW  = $clog2(LATENCY + 2);
  localparam int unsigned DYNW  = $clog2(SIZESRDYN);
  localparam int unsigned STATW = $clog2(SIZESRSTAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RECV, S_FIN} state_e;

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [LATW-1:0]         lat_cnt_q, lat_cnt_d;
  logic [SIZECNT-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SIZECNT-1:0]      err_q, err_d;
  logic                    match_q, match_d;
  logic [SIZESRDYN-1:0]    rx_dyn_q, rx_dyn_d;
  logic [SIZESRSTAT-1:0]   rx_stat_q, rx_stat_d;

  logic [DYNW-1:0]         dyn_idx;
  logic [STATW-1:0]        stat_idx;
  logic                    exp_bit;
  logic                    last_bit;

  // Bit k of the stream is checked against EXP[N-1-k].
  always_comb begin
    dyn_idx  = DYNW'(SIZESRDYN - 1) - bit_cnt_q[DYNW-1:0];
    stat_idx = STATW'(SIZESRSTAT - 1) - STATW'(bit_cnt_q);
    exp_bit  = mode_q ? EXP_STAT[stat_idx] : EXP_DYN[dyn_idx];
    last_bit = mode_q ? (bit_cnt_q == SIZECNT'(SIZESRSTAT - 1))
                      : (bit_cnt_q == SIZECNT'(SIZESRDYN - 1));
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lat_cnt_d = lat_cnt_q;
    bit_cnt_d = bit_cnt_q;
    err_d     = err_q;
    match_d   = match_q;
    rx_dyn_d  = rx_dyn_q;
    rx_stat_d = rx_stat_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          mode_d    = MODE;
          err_d     = '0;
          match_d   = 1'b0;
          lat_cnt_d = '0;
          bit_cnt_d = '0;
          if (MODE) rx_stat_d = '0;
          else      rx_dyn_d  = '0;
          state_d   = (LATENCY == 0) ? S_RECV : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == LATW'(LATENCY - 1)) state_d = S_RECV;
        else lat_cnt_d = lat_cnt_q + LATW'(1);
      end
      S_RECV: begin
        if (mode_q) rx_stat_d = {rx_stat_q[SIZESRSTAT-2:0], signal_in};
        else        rx_dyn_d  = {rx_dyn_q[SIZESRDYN-2:0], signal_in};
        if (signal_in != exp_bit) err_d = err_q + SIZECNT'(1);
        bit_cnt_d = bit_cnt_q + SIZECNT'(1);
        if (last_bit) begin
          // MATCH must include the final bit's comparison, hence err_d.
          match_d = (err_d == '0);
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      lat_cnt_q <= '0;
      bit_cnt_q <= '0;
      err_q     <= '0;
      match_q   <= 1'b0;
      rx_dyn_q  <= '0;
      rx_stat_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lat_cnt_q <= lat_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      err_q     <= err_d;
      match_q   <= match_d;
      rx_dyn_q  <= rx_dyn_d;
      rx_stat_q <= rx_stat_d;
    end
  end

  always_comb begin
    BUSY    = (state_q != S_IDLE);
    DONE    = (state_q == S_FIN);
    MATCH   = match_q;
    ERR_CNT = err_q;
    RX_DYN  = rx_dyn_q;
    RX_STAT = rx_stat_q;
  end

endmodule

// File: tb/tb_pattern_receiver.sv
// Bench for pattern_receiver: edge-timeline model checked every cycle on two
// instances (LATENCY=1 and LATENCY=0) plus hand-computed frame results.
module tb_pattern_receiver;

  localparam logic [15:0] EXP_D = 16'hABCD;
  localparam logic [87:0] EXP_S = 88'h123456789ABCDEF1234567;

  logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0, MODE = 1'b0, signal_in = 1'b0;

  logic        busy1, done1, match1, busy0, done0, match0;
  logic [6:0]  err1, err0;
  logic [15:0] rxd1, rxd0;
  logic [87:0] rxs1, rxs0;

  always #5 CLK = ~CLK;

  pattern_receiver #(.LATENCY(1)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .signal_in(signal_in),
    .BUSY(busy1), .DONE(done1), .MATCH(match1), .ERR_CNT(err1),
    .RX_DYN(rxd1), .RX_STAT(rxs1)
  );

  pattern_receiver #(.LATENCY(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE), .signal_in(signal_in),
    .BUSY(busy0), .DONE(done0), .MATCH(match0), .ERR_CNT(err0),
    .RX_DYN(rxd0), .RX_STAT(rxs0)
  );

  // Frame model: t counts edges since the accepted START edge.
  typedef struct {
    bit        active;
    int        t;
    bit        mode;
    int        err;
    bit        match;
    bit [15:0] rx_dyn;
    bit [87:0] rx_stat;
  } model_t;

  model_t m1, m0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_q0[$];
  bit match_at0[$];

  function automatic model_t mreset();
    model_t m;
    m.active = 0; m.t = 0; m.mode = 0; m.err = 0; m.match = 0;
    m.rx_dyn = '0; m.rx_stat = '0;
    return m;
  endfunction

  function automatic int flen(bit md);
    return md ? 88 : 16;
  endfunction

  function automatic model_t step(model_t m, int lat, bit st, bit md, bit din);
    bit [87:0] es;
    bit [15:0] ed;
    bit        want;
    int        n, k;
    es = EXP_S;
    ed = EXP_D;
    if (!m.active) begin
      if (st) begin
        m.active = 1; m.t = 0; m.mode = md; m.err = 0; m.match = 0;
        if (md) m.rx_stat = '0;
        else    m.rx_dyn  = '0;
      end
      return m;
    end
    m.t++;
    n = flen(m.mode);
    if (m.t >= lat + 1 && m.t <= lat + n) begin
      k = m.t - lat - 1;
      want = m.mode ? es[7'(n - 1 - k)] : ed[4'(n - 1 - k)];
      if (m.mode) m.rx_stat = {m.rx_stat[86:0], din};
      else        m.rx_dyn  = {m.rx_dyn[14:0], din};
      if (din != want) m.err++;
      if (m.t == lat + n) m.match = (m.err == 0);
    end else if (m.t == lat + n + 1) begin
      m.active = 0;
    end
    return m;
  endfunction

  function automatic bit mdone(model_t m, int lat);
    return m.active && (m.t == lat + flen(m.mode));
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m1 = mreset();
      m0 = mreset();
    end else begin
      m1 = step(m1, 1, START, MODE, signal_in);
      m0 = step(m0, 0, START, MODE, signal_in);
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [87:0] act, input logic [87:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge CLK) begin
    chk("m_busy_l1",  88'(busy1),  88'(m1.active));
    chk("m_done_l1",  88'(done1),  88'(mdone(m1, 1)));
    chk("m_match_l1", 88'(match1), 88'(m1.match));
    chk("m_err_l1",   88'(err1),   88'(m1.err));
    chk("m_rxdyn_l1", 88'(rxd1),   88'(m1.rx_dyn));
    chk("m_rxstat_l1", rxs1,       m1.rx_stat);
    chk("m_busy_l0",  88'(busy0),  88'(m0.active));
    chk("m_done_l0",  88'(done0),  88'(mdone(m0, 0)));
    chk("m_match_l0", 88'(match0), 88'(m0.match));
    chk("m_err_l0",   88'(err0),   88'(m0.err));
    chk("m_rxdyn_l0", 88'(rxd0),   88'(m0.rx_dyn));
    chk("m_rxstat_l0", rxs0,       m0.rx_stat);
    if (done0) begin
      done_q0.push_back(cyc);
      match_at0.push_back(match0);
    end
  end

  task automatic drive(input bit st, input bit md, input bit d);
    START = st; MODE = md; signal_in = d;
    @(posedge CLK);
    #1;
  endtask

  // Frame on the LATENCY=1 instance; MODE is flipped after START to show it is ignored.
  task automatic run_frame(input bit md, input logic [87:0] pat, input bit hold_start);
    int n;
    n = flen(md);
    drive(1'b1, md, 1'b0);
    drive(hold_start, ~md, 1'b0);
    for (int k = 0; k < n - 1; k++) drive(hold_start, ~md, pat[7'(n - 1 - k)]);
    chk("done_low_before_last", 88'(done1), 88'(0));
    drive(hold_start, ~md, pat[0]);
    chk("done_pulse", 88'(done1), 88'(1));
    chk("busy_in_fin", 88'(busy1), 88'(1));
    drive(hold_start, ~md, 1'b0);
    chk("done_cleared", 88'(done1), 88'(0));
    chk("busy_cleared", 88'(busy1), 88'(0));
    START = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  88'(busy1),  88'(0));
    chk({tag, "_done"},  88'(done1),  88'(0));
    chk({tag, "_match"}, 88'(match1), 88'(0));
    chk({tag, "_err"},   88'(err1),   88'(0));
    chk({tag, "_rxdyn"}, 88'(rxd1),   88'(0));
    chk({tag, "_rxstat"}, rxs1,       88'(0));
  endtask

  initial begin
    logic [87:0] flip;
    logic [87:0] es;
    es = EXP_S;
    flip = '0;
    flip[87] = 1'b1;
    flip[0] = 1'b1;

    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    #2 RST_N = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    run_frame(1'b0, 88'(EXP_D), 1'b0);
    chk("dyn_rx",      88'(rxd1),   88'(16'hABCD));
    chk("dyn_err",     88'(err1),   88'(0));
    chk("dyn_match",   88'(match1), 88'(1));
    chk("dyn_stat_untouched", rxs1, 88'(0));
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("dyn_hold_rx",    88'(rxd1),   88'(16'hABCD));
    chk("dyn_hold_match", 88'(match1), 88'(1));

    run_frame(1'b1, EXP_S, 1'b0);
    chk("stat_rx",    rxs1,         88'h123456789ABCDEF1234567);
    chk("stat_err",   88'(err1),    88'(0));
    chk("stat_match", 88'(match1),  88'(1));
    chk("stat_dyn_untouched", 88'(rxd1), 88'(16'hABCD));
    drive(1'b0, 1'b0, 1'b0);

    run_frame(1'b1, EXP_S ^ flip, 1'b0);
    chk("err2_cnt",   88'(err1),   88'(2));
    chk("err2_match", 88'(match1), 88'(0));
    chk("err2_rx",    rxs1,        88'h923456789ABCDEF1234566);
    drive(1'b0, 1'b0, 1'b0);

    run_frame(1'b1, ~EXP_S, 1'b0);
    chk("inv_cnt",   88'(err1),   88'(88));
    chk("inv_match", 88'(match1), 88'(0));
    chk("inv_rx",    rxs1,        ~88'h123456789ABCDEF1234567);
    drive(1'b0, 1'b0, 1'b0);

    run_frame(1'b0, 88'(EXP_D), 1'b1);
    chk("restart_rx",    88'(rxd1),   88'(16'hABCD));
    chk("restart_match", 88'(match1), 88'(1));
    chk("restart_err",   88'(err1),   88'(0));
    drive(1'b0, 1'b0, 1'b0);
    chk("restart_no_second_frame", 88'(busy1), 88'(0));

    // Abort a static frame while bit 5 is on the line.
    repeat (100) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, es[7'(87 - k)]);
    chk("pre_abort_busy", 88'(busy1), 88'(1));
    signal_in = es[82];
    #2 RST_N = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk_all_zero("post_abort");
    run_frame(1'b0, 88'(EXP_D), 1'b0);
    chk("post_abort_match", 88'(match1), 88'(1));
    chk("post_abort_rx",    88'(rxd1),   88'(16'hABCD));

    // Back-to-back dynamic frames on the LATENCY=0 instance, START held high.
    repeat (100) drive(1'b0, 1'b0, 1'b0);
    done_q0.delete();
    match_at0.delete();
    for (int f = 0; f < 2; f++) begin
      drive(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, EXP_D[4'(15 - k)]);
      drive(1'b1, 1'b0, 1'b0);
    end
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    chk("b2b_done_count", 88'(done_q0.size()), 88'(2));
    if (done_q0.size() >= 2) begin
      chk("b2b_spacing", 88'(done_q0[1] - done_q0[0]), 88'(18));
      chk("b2b_match0",  88'(match_at0[0]), 88'(1));
      chk("b2b_match1",  88'(match_at0[1]), 88'(1));
    end
    chk("b2b_rx", 88'(rxd0), 88'(16'hABCD));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_receiver.md
Name: pattern_receiver

Overview:
- Serial receiver/checker at the far end of the shift-register pattern generator link.
- Deserializes the 1-bit MSB-first stream carrying either the 16-bit dynamic pattern or the 88-bit static pattern.
- Stores the received word, compares it bit-by-bit against the expected constant, and reports match/mismatch plus an error count.
- Used in loopback self-test of the generator and as the sink on the receiving board.

Parameters:
- SIZESRSTAT, 88, static pattern length in bits.
- SIZESRDYN, 16, dynamic pattern length in bits.
- SIZECNT, 7, width of the bit counter and ERR_CNT; must satisfy 2^SIZECNT > SIZESRSTAT.
- LATENCY, 1, number of cycles skipped after START before the first bit is sampled; covers the generator output register.
- EXP_DYN, 16'hABCD, expected dynamic pattern.
- EXP_STAT, 88'h123456789ABCDEF1234567, expected static pattern.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous reset, active low.
- START  input  1  frame start request; sampled only in IDLE.
- MODE  input  1  frame type, latched at START: 0 = dynamic (SIZESRDYN bits), 1 = static (SIZESRSTAT bits).
- signal_in  input  1  serial data, MSB first.
- BUSY  output  1  high from the edge after START is accepted until the return to IDLE.
- DONE  output  1  one-cycle pulse marking the end of a frame.
- MATCH  output  1  1 when the last frame had ERR_CNT==0; valid from DONE, held until the next accepted START.
- ERR_CNT  output  SIZECNT  number of mismatching bits in the current/last frame.
- RX_DYN  output  SIZESRDYN  received dynamic word.
- RX_STAT  output  SIZESRSTAT  received static word.

Behaviour:
- Reset (asynchronous): state IDLE; BUSY, DONE, MATCH = 0; ERR_CNT, RX_DYN, RX_STAT, bit counter, latched mode = 0. Reset mid-frame aborts the frame with no DONE.
- FSM states: IDLE, WAIT, RECV, FIN.
- IDLE: START=1 at an edge →
  - latch MODE;
  - clear ERR_CNT and MATCH;
  - clear only the selected RX register; the other register holds;
  - go to WAIT, or to RECV if LATENCY=0.
  - BUSY=1 from this edge.
- WAIT: count LATENCY edges, then go to RECV. No sampling in WAIT.
- RECV: sample signal_in at each edge, N = SIZESRDYN or SIZESRSTAT edges.
  - First sampled bit is at the (LATENCY+1)th edge after the START edge.
  - Selected RX register shifts left with signal_in inserted at the LSB; after N bits, bit 0 of the stream sits in RX[N-1].
  - Bit index k (0 = first) is compared with EXP[N-1-k]; ERR_CNT increments on each mismatch.
  - At the edge sampling bit N-1, go to FIN.
- FIN (exactly one cycle):
  - DONE=1, BUSY=1;
  - MATCH = (ERR_CNT==0), registered on entry to FIN;
  - next edge → IDLE, BUSY=0.
- START in WAIT/RECV/FIN is ignored (no restart, no effect on counters). START in IDLE at the edge that leaves FIN is accepted normally.
- MODE changes after the START edge have no effect on the current frame.
- ERR_CNT never wraps, since its maximum value 88 is less than 128.
- Outputs RX_*, ERR_CNT, and MATCH hold their values in IDLE until the next accepted START.
- Frame length (START edge to DONE) = LATENCY + N + 1 cycles; back-to-back frame period = LATENCY + N + 2 cycles.

Test Plan:
- Dynamic frame, correct data: LATENCY=1, START+MODE=0, stream 16'hABCD MSB-first from cycle 2 → DONE at cycle 18, RX_DYN=16'hABCD, ERR_CNT=0, MATCH=1; RX_STAT untouched.
- Static frame, correct data: START+MODE=1, stream 88'h123456789ABCDEF1234567 → DONE after 90 cycles, RX_STAT equals the pattern, MATCH=1.
- Error detection:
  - static frame with bit index 0 and bit index 87 inverted → ERR_CNT=2, MATCH=0, RX_STAT = pattern ^ {1'b1,86'b0,1'b1};
  - fully inverted static stream → ERR_CNT=7'd88.
- START re-asserted every cycle during an active dynamic frame → single DONE pulse, result unchanged.
- RST_N low at RECV bit 5 of a static frame → all outputs 0 immediately (asynchronous), state IDLE, no DONE; a following correct dynamic frame → MATCH=1.
- Back-to-back: START held high across two frames with LATENCY=0 → DONE pulses 18 cycles apart (16+2), both MATCH=1.
